// File: rtl/branch_predict_unit.sv
// branch_predict_unit
//   Direct-mapped BTB with 2-bit saturating counters for fetch-time
//   prediction. It resolves conditional branches in decode and drives one
//   redirect request, where an execute-stage PC change has priority.
//   Table and performance-counter updates land on the edge after resolution.
//
// Ports
//   i_clk, i_rst         rising-edge clock, synchronous active-high reset
//   i_if_pc              fetch PC          -> o_pred_taken, o_pred_pc
//   i_id_*               decode branch info (valid, branch, opcode, pc,
//                        carried prediction)
//   i_imm                branch offset in words
//   i_data_r1/r2         forwarded operands
//   i_es_change_pc/pc    execute-stage redirect (jump/jal/jr)
//   i_stat_clr           clears both performance counters
//   o_redirect/_pc       flush request and corrected PC
//   o_br_cnt, o_mp_cnt   resolved / mispredicted branch counters (saturating)
//
// Opcode encodings default to the MIPS primary opcodes for BEQ/BNE/BLEZ/BGTZ.
module branch_predict_unit #(
  parameter int PC_WIDTH     = 32,
  parameter int DWIDTH       = 32,
  parameter int IMM_WIDTH    = 16,
  parameter int ENTRIES      = 16,
  parameter int EXT_BRANCH   = 0,
  parameter int CNT_WIDTH    = 16,
  parameter int OPCODE_WIDTH = 6,
  parameter logic [OPCODE_WIDTH-1:0] OP_BEQ  = 'h04,
  parameter logic [OPCODE_WIDTH-1:0] OP_BNE  = 'h05,
  parameter logic [OPCODE_WIDTH-1:0] OP_BLEZ = 'h06,
  parameter logic [OPCODE_WIDTH-1:0] OP_BGTZ = 'h07
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [PC_WIDTH-1:0]     i_if_pc,
  output logic                    o_pred_taken,
  output logic [PC_WIDTH-1:0]     o_pred_pc,
  input  logic                    i_id_valid,
  input  logic                    i_id_branch,
  input  logic [OPCODE_WIDTH-1:0] i_id_opcode,
  input  logic [PC_WIDTH-1:0]     i_id_pc,
  input  logic                    i_id_pred_taken,
  input  logic [PC_WIDTH-1:0]     i_id_pred_pc,
  input  logic [IMM_WIDTH-1:0]    i_imm,
  input  logic [DWIDTH-1:0]       i_data_r1,
  input  logic [DWIDTH-1:0]       i_data_r2,
  input  logic                    i_es_change_pc,
  input  logic [PC_WIDTH-1:0]     i_es_pc,
  input  logic                    i_stat_clr,
  output logic                    o_redirect,
  output logic [PC_WIDTH-1:0]     o_redirect_pc,
  output logic [CNT_WIDTH-1:0]    o_br_cnt,
  output logic [CNT_WIDTH-1:0]    o_mp_cnt
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = PC_WIDTH - IDX_W - 2;

  function automatic logic [1:0] ctr_sat_inc(input logic [1:0] c);
    return (c == 2'b11) ? c : c + 2'b01;
  endfunction

  function automatic logic [1:0] ctr_sat_dec(input logic [1:0] c);
    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

  function automatic logic [CNT_WIDTH-1:0] cnt_sat_inc(input logic [CNT_WIDTH-1:0] c,
                                                       input logic en);
    return (en && (c != '1)) ? c + CNT_WIDTH'(1) : c;
  endfunction

  logic                tbl_valid  [ENTRIES];
  logic [1:0]          tbl_ctr    [ENTRIES];
  logic [TAG_W-1:0]    tbl_tag    [ENTRIES];
  logic [PC_WIDTH-1:0] tbl_target [ENTRIES];

  // Word-offset bits of the PCs never take part in indexing or tagging.
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{i_if_pc[1:0], i_id_pc[1:0]};

  // ---- fetch lookup (combinational, reads registered table) ----
  logic [IDX_W-1:0] if_idx;
  logic             if_hit;
  assign if_idx       = i_if_pc[IDX_W+1:2];
  assign if_hit       = tbl_valid[if_idx] && (tbl_tag[if_idx] == i_if_pc[PC_WIDTH-1:IDX_W+2]);
  assign o_pred_taken = if_hit && tbl_ctr[if_idx][1];
  assign o_pred_pc    = o_pred_taken ? tbl_target[if_idx] : i_if_pc + PC_WIDTH'(4);

  // ---- decode resolve ----
  logic signed [DWIDTH-1:0]   r1_s;
  logic signed [PC_WIDTH-1:0] imm_sext;
  logic [PC_WIDTH-1:0]        id_pc_plus4;
  logic [PC_WIDTH-1:0]        br_target;
  logic                       r1_nonpos;
  logic                       taken;
  logic                       res;
  logic                       mispredict;
  logic [IDX_W-1:0]           id_idx;
  logic                       id_hit;

  assign r1_s        = i_data_r1;
  assign imm_sext    = PC_WIDTH'(signed'(i_imm));
  assign id_pc_plus4 = i_id_pc + PC_WIDTH'(4);
  assign br_target   = id_pc_plus4 + PC_WIDTH'(imm_sext <<< 2);
  assign r1_nonpos   = r1_s[DWIDTH-1] || (r1_s == '0);

  always_comb begin
    taken = 1'b0;
    if (i_id_opcode == OP_BEQ)                        taken = (i_data_r1 == i_data_r2);
    else if (i_id_opcode == OP_BNE)                   taken = (i_data_r1 != i_data_r2);
    else if (EXT_BRANCH != 0 && i_id_opcode == OP_BLEZ) taken = r1_nonpos;
    else if (EXT_BRANCH != 0 && i_id_opcode == OP_BGTZ) taken = !r1_nonpos;
  end

  assign res        = i_id_valid && i_id_branch && !i_es_change_pc;
  assign mispredict = res && ((i_id_pred_taken != taken) ||
                              (taken && (i_id_pred_pc != br_target)));
  assign id_idx     = i_id_pc[IDX_W+1:2];
  assign id_hit     = tbl_valid[id_idx] && (tbl_tag[id_idx] == i_id_pc[PC_WIDTH-1:IDX_W+2]);

  // ---- redirect (execute stage outranks decode) ----
  always_comb begin
    o_redirect    = 1'b0;
    o_redirect_pc = id_pc_plus4;
    if (i_es_change_pc) begin
      o_redirect    = 1'b1;
      o_redirect_pc = i_es_pc;
    end else if (mispredict) begin
      o_redirect    = 1'b1;
      o_redirect_pc = taken ? br_target : id_pc_plus4;
    end
  end

  // ---- table control state and performance counters ----
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        tbl_valid[i] <= 1'b0;
        tbl_ctr[i]   <= 2'b01;
      end
      o_br_cnt <= '0;
      o_mp_cnt <= '0;
    end else begin
      if (res) begin
        if (id_hit)
          tbl_ctr[id_idx] <= taken ? ctr_sat_inc(tbl_ctr[id_idx]) : ctr_sat_dec(tbl_ctr[id_idx]);
        else if (taken) begin
          tbl_valid[id_idx] <= 1'b1;
          tbl_ctr[id_idx]   <= 2'b10;
        end
      end
      if (i_stat_clr) begin
        o_br_cnt <= '0;
        o_mp_cnt <= '0;
      end else begin
        o_br_cnt <= cnt_sat_inc(o_br_cnt, res);
        o_mp_cnt <= cnt_sat_inc(o_mp_cnt, mispredict);
      end
    end
  end

  // ---- table data: tag/target written on every taken resolve (hit or allocate) ----
  always_ff @(posedge i_clk) begin
    if (res && taken && !i_rst) begin
      tbl_tag[id_idx]    <= i_id_pc[PC_WIDTH-1:IDX_W+2];
      tbl_target[id_idx] <= br_target;
    end
  end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit. Two instances share stimulus:
// u_dut (defaults with EXT_BRANCH=1) and u_small (CNT_WIDTH=2, EXT_BRANCH=0).
module tb_branch_predict_unit;

  localparam logic [5:0] BEQ  = 6'h04;
  localparam logic [5:0] BNE  = 6'h05;
  localparam logic [5:0] BLEZ = 6'h06;
  localparam logic [5:0] BGTZ = 6'h07;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc;
  logic        id_valid, id_branch, id_pred_taken;
  logic [5:0]  id_opcode;
  logic [31:0] id_pc, id_pred_pc;
  logic [15:0] imm;
  logic [31:0] r1, r2;
  logic        es_change_pc;
  logic [31:0] es_pc;
  logic        stat_clr;

  logic        pred_taken, redirect;
  logic [31:0] pred_pc, redirect_pc;
  logic [15:0] br_cnt, mp_cnt;
  logic        s_pred_taken, s_redirect;
  logic [31:0] s_pred_pc, s_redirect_pc;
  logic [1:0]  s_br_cnt, s_mp_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_predict_unit #(.EXT_BRANCH(1)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_if_pc(if_pc),
    .o_pred_taken(pred_taken), .o_pred_pc(pred_pc),
    .i_id_valid(id_valid), .i_id_branch(id_branch), .i_id_opcode(id_opcode),
    .i_id_pc(id_pc), .i_id_pred_taken(id_pred_taken), .i_id_pred_pc(id_pred_pc),
    .i_imm(imm), .i_data_r1(r1), .i_data_r2(r2),
    .i_es_change_pc(es_change_pc), .i_es_pc(es_pc), .i_stat_clr(stat_clr),
    .o_redirect(redirect), .o_redirect_pc(redirect_pc),
    .o_br_cnt(br_cnt), .o_mp_cnt(mp_cnt)
  );

  branch_predict_unit #(.EXT_BRANCH(0), .CNT_WIDTH(2)) u_small (
    .i_clk(clk), .i_rst(rst), .i_if_pc(if_pc),
    .o_pred_taken(s_pred_taken), .o_pred_pc(s_pred_pc),
    .i_id_valid(id_valid), .i_id_branch(id_branch), .i_id_opcode(id_opcode),
    .i_id_pc(id_pc), .i_id_pred_taken(id_pred_taken), .i_id_pred_pc(id_pred_pc),
    .i_imm(imm), .i_data_r1(r1), .i_data_r2(r2),
    .i_es_change_pc(es_change_pc), .i_es_pc(es_pc), .i_stat_clr(stat_clr),
    .o_redirect(s_redirect), .o_redirect_pc(s_redirect_pc),
    .o_br_cnt(s_br_cnt), .o_mp_cnt(s_mp_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic resolve(input logic [5:0] op, input logic [31:0] pc, input logic [15:0] im,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic pt, input logic [31:0] ppc);
    id_valid = 1'b1; id_branch = 1'b1; id_opcode = op; id_pc = pc; imm = im;
    r1 = a; r2 = b; id_pred_taken = pt; id_pred_pc = ppc;
    #1;
  endtask

  // Advance past one rising edge and return the decode/execute/clear
  // controls to idle so nothing resolves twice.
  task automatic tick_idle();
    @(posedge clk);
    #1;
    id_valid = 1'b0; es_change_pc = 1'b0; stat_clr = 1'b0; rst = 1'b0;
    #1;
  endtask

  task automatic lookup(input string tag, input logic [31:0] pc,
                        input logic exp_taken, input logic [31:0] exp_pc);
    if_pc = pc;
    #1;
    check({tag, "_taken"}, {31'd0, pred_taken}, {31'd0, exp_taken});
    check({tag, "_pc"}, pred_pc, exp_pc);
  endtask

  initial begin
    rst = 1'b1; if_pc = '0; id_valid = 1'b0; id_branch = 1'b0; id_opcode = '0;
    id_pc = '0; id_pred_taken = 1'b0; id_pred_pc = '0; imm = '0; r1 = '0; r2 = '0;
    es_change_pc = 1'b0; es_pc = '0; stat_clr = 1'b0;
    @(posedge clk); #1;
    tick_idle();

    // Reset state
    lookup("rst_lookup", 32'h40, 1'b0, 32'h44);
    check("rst_br", {16'd0, br_cnt}, 32'd0);
    check("rst_mp", {16'd0, mp_cnt}, 32'd0);
    check("rst_redirect", {31'd0, redirect}, 32'd0);

    // BEQ taken, predicted not taken: mispredict to 0x50, allocate ctr=10
    resolve(BEQ, 32'h40, 16'd3, 32'd5, 32'd5, 1'b0, 32'h44);
    check("beq_redirect", {31'd0, redirect}, 32'd1);
    check("beq_redirect_pc", redirect_pc, 32'h50);
    tick_idle();
    check("beq_mp", {16'd0, mp_cnt}, 32'd1);
    check("beq_br", {16'd0, br_cnt}, 32'd1);
    lookup("beq_alloc", 32'h40, 1'b1, 32'h50);

    // Not taken, predicted taken: ctr 10->01, redirect to fall-through
    resolve(BEQ, 32'h40, 16'd3, 32'd5, 32'd6, 1'b1, 32'h50);
    check("nt1_redirect", {31'd0, redirect}, 32'd1);
    check("nt1_redirect_pc", redirect_pc, 32'h44);
    tick_idle();
    lookup("nt1_lookup", 32'h40, 1'b0, 32'h44);

    // Not taken, predicted not taken: no redirect, ctr 01->00
    resolve(BEQ, 32'h40, 16'd3, 32'd5, 32'd6, 1'b0, 32'h44);
    check("nt2_redirect", {31'd0, redirect}, 32'd0);
    check("nt2_redirect_pc", redirect_pc, 32'h44);
    tick_idle();
    check("nt2_mp", {16'd0, mp_cnt}, 32'd2);

    // Third not-taken must hold ctr at 00 (a wrap would predict taken)
    resolve(BEQ, 32'h40, 16'd3, 32'd7, 32'd6, 1'b0, 32'h44);
    tick_idle();
    lookup("nt3_floor", 32'h40, 1'b0, 32'h44);

    // Taken on a hit from 00: ctr->01, still predicts not taken
    resolve(BEQ, 32'h40, 16'd3, 32'd9, 32'd9, 1'b0, 32'h44);
    check("tk_hit_redirect_pc", redirect_pc, 32'h50);
    tick_idle();
    lookup("tk_hit_lookup", 32'h40, 1'b0, 32'h44);
    check("br5", {16'd0, br_cnt}, 32'd5);
    check("mp3", {16'd0, mp_cnt}, 32'd3);
    check("small_br_sat", {30'd0, s_br_cnt}, 32'd3);
    check("small_mp_sat", {30'd0, s_mp_cnt}, 32'd3);

    // Execute override with a BNE mispredict: no table or counter change
    es_change_pc = 1'b1; es_pc = 32'h1000;
    resolve(BNE, 32'h40, 16'd3, 32'd1, 32'd2, 1'b0, 32'h44);
    check("es_redirect", {31'd0, redirect}, 32'd1);
    check("es_redirect_pc", redirect_pc, 32'h1000);
    tick_idle();
    check("es_br", {16'd0, br_cnt}, 32'd5);
    check("es_mp", {16'd0, mp_cnt}, 32'd3);
    lookup("es_table", 32'h40, 1'b0, 32'h44);

    // Alias: 0x80 shares index 0 with 0x40 and evicts it
    resolve(BEQ, 32'h80, 16'd0, 32'd1, 32'd1, 1'b0, 32'h84);
    check("alias_redirect_pc", redirect_pc, 32'h84);
    tick_idle();
    lookup("alias_new", 32'h80, 1'b1, 32'h84);
    lookup("alias_old", 32'h40, 1'b0, 32'h44);

    // Hit, taken, wrong predicted target (negative offset): target rewritten
    resolve(BEQ, 32'h80, 16'hFFFF, 32'd1, 32'd1, 1'b1, 32'h84);
    check("tgt_redirect", {31'd0, redirect}, 32'd1);
    check("tgt_redirect_pc", redirect_pc, 32'h80);
    tick_idle();
    lookup("tgt_lookup", 32'h80, 1'b1, 32'h80);
    check("br7", {16'd0, br_cnt}, 32'd7);
    check("mp5", {16'd0, mp_cnt}, 32'd5);

    // BLEZ with r1=-1: taken when enabled, not taken when disabled
    resolve(BLEZ, 32'h204, 16'd2, 32'hFFFF_FFFF, 32'd0, 1'b0, 32'h208);
    check("blez_redirect_pc", redirect_pc, 32'h210);
    check("blez_redirect", {31'd0, redirect}, 32'd1);
    check("blez_small_redirect", {31'd0, s_redirect}, 32'd0);
    check("blez_small_redirect_pc", s_redirect_pc, 32'h208);
    tick_idle();
    lookup("blez_lookup", 32'h204, 1'b1, 32'h210);
    check("blez_small_lookup", {31'd0, s_pred_taken}, 32'd0);
    check("blez_small_pc", s_pred_pc, 32'h208);

    // BGTZ with r1=0: not taken, predicted taken -> redirect to fall-through
    resolve(BGTZ, 32'h204, 16'd2, 32'd0, 32'd0, 1'b1, 32'h210);
    check("bgtz_redirect_pc", redirect_pc, 32'h208);
    check("bgtz_small_redirect", {31'd0, s_redirect}, 32'd1);
    tick_idle();
    lookup("bgtz_lookup", 32'h204, 1'b0, 32'h208);
    check("br9", {16'd0, br_cnt}, 32'd9);
    check("mp7", {16'd0, mp_cnt}, 32'd7);

    // Stat clear together with a mispredicted resolve: clear wins
    stat_clr = 1'b1;
    resolve(BEQ, 32'h308, 16'd1, 32'd1, 32'd2, 1'b1, 32'h310);
    tick_idle();
    check("clr_br", {16'd0, br_cnt}, 32'd0);
    check("clr_mp", {16'd0, mp_cnt}, 32'd0);
    check("clr_small_br", {30'd0, s_br_cnt}, 32'd0);
    check("clr_small_mp", {30'd0, s_mp_cnt}, 32'd0);
    lookup("clr_miss_nt", 32'h308, 1'b0, 32'h30C);

    // Counting resumes after the clear
    resolve(BEQ, 32'h308, 16'd1, 32'd1, 32'd2, 1'b0, 32'h30C);
    tick_idle();
    check("post_clr_br", {16'd0, br_cnt}, 32'd1);
    check("post_clr_mp", {16'd0, mp_cnt}, 32'd0);

    // Reset concurrent with a taken resolve: nothing allocated, all cleared
    rst = 1'b1;
    resolve(BEQ, 32'h30C, 16'd1, 32'd4, 32'd4, 1'b0, 32'h310);
    tick_idle();
    lookup("rst_resolve", 32'h30C, 1'b0, 32'h310);
    lookup("rst_clears_80", 32'h80, 1'b0, 32'h84);
    check("rst_br_cnt", {16'd0, br_cnt}, 32'd0);
    check("rst_small_br", {30'd0, s_br_cnt}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_predict_unit.md
# branch_predict_unit

Parametrised branch predictor and resolver for the MIPS pipeline. A direct-mapped branch target buffer with 2-bit saturating counters predicts at fetch. BEQ/BNE (and optionally BLEZ/BGTZ) resolve in decode. The unit drives a single redirect request, with an execute-stage PC change taking priority. Table state and saturating performance counters are updated on the clock edge after resolution.

## Interface
- PC_WIDTH, 32, PC width (byte address)
- DWIDTH, 32, register data width
- IMM_WIDTH, 16, branch immediate width
- ENTRIES, 16, BTB entries; power of two, ≥2; IDX_W = log2(ENTRIES)
- EXT_BRANCH, 0, 1 enables BLEZ/BGTZ resolution
- CNT_WIDTH, 16, performance counter width

Ports:
- i_clk  in  1  clock, rising edge
- i_rst  in  1  reset, synchronous, active-high
- i_if_pc  in  PC_WIDTH  PC of instruction being fetched
- o_pred_taken  out  1  fetch prediction
- o_pred_pc  out  PC_WIDTH  predicted next PC
- i_id_valid  in  1  decode slot holds a live instruction
- i_id_branch  in  1  decode instruction is a conditional branch
- i_id_opcode  in  `OPCODE_WIDTH  decode opcode (`BEQ/`BNE/`BLEZ/`BGTZ from header.vh)
- i_id_pc  in  PC_WIDTH  PC of the decode branch
- i_id_pred_taken  in  1  prediction carried with the branch from fetch
- i_id_pred_pc  in  PC_WIDTH  predicted PC carried with the branch
- i_imm  in  IMM_WIDTH  branch offset (words)
- i_data_r1, i_data_r2  in  DWIDTH  forwarded operands
- i_es_change_pc  in  1  execute stage requests PC change (jump/jal/jr)
- i_es_pc  in  PC_WIDTH  execute-stage target
- i_stat_clr  in  1  synchronous clear of performance counters
- o_redirect  out  1  flush younger stages and load o_redirect_pc
- o_redirect_pc  out  PC_WIDTH  corrected PC
- o_br_cnt  out  CNT_WIDTH  resolved branches
- o_mp_cnt  out  CNT_WIDTH  mispredicted branches

## Operation
- Entry layout: valid, tag = pc[PC_WIDTH-1:IDX_W+2], target, ctr[1:0]. Index = pc[IDX_W+1:2].
- Fetch lookup is combinational from registered table.
  - hit = valid && tag match.
  - o_pred_taken = hit && ctr[1].
  - o_pred_pc = o_pred_taken ? target : i_if_pc+4.
- Resolve: res = i_id_valid && i_id_branch && !i_es_change_pc.
  - target = i_id_pc + 4 + (sext(i_imm) << 2), mod 2^PC_WIDTH.
  - Taken conditions:
    - BEQ: r1 == r2.
    - BNE: r1 != r2.
    - BLEZ (EXT_BRANCH=1): signed r1 ≤ 0.
    - BGTZ (EXT_BRANCH=1): signed r1 > 0.
    - Any other opcode, or BLEZ/BGTZ with EXT_BRANCH=0: not taken.
  - actual = taken ? target : i_id_pc+4.
  - mispredict = res && ((i_id_pred_taken != taken) || (taken && i_id_pred_pc != target)).
- Redirect, combinational, priority order:
  1. i_es_change_pc: o_redirect=1, o_redirect_pc=i_es_pc.
  2. Else mispredict: o_redirect=1, o_redirect_pc=actual.
  3. Else o_redirect=0, o_redirect_pc=i_id_pc+4.
- Table update at the edge when res:
  - Hit and taken: ctr saturating increment (max 11); target rewritten.
  - Hit and not taken: ctr saturating decrement (min 00).
  - Miss and taken: allocate (valid=1, tag, target, ctr=10), replacing the occupant.
  - Miss and not taken: no write.
- Counters at the edge: o_br_cnt += res; o_mp_cnt += mispredict. Both saturate at all-ones. i_stat_clr zeroes both and overrides an increment in the same cycle.

## Timing
- Prediction and redirect: 0-cycle combinational. Table and counter effects become visible 1 cycle after the resolving edge.
- Same-cycle fetch lookup and resolve write to the same index: fetch sees old contents (no bypass).
- Execute override suppresses decode table and counter updates in that cycle.
- Reset: all entries valid=0 with ctr=01, counters 0. With i_es_change_pc=0 and i_id_valid=0, outputs are o_pred_taken=0, o_pred_pc=i_if_pc+4, o_redirect=0.
- i_rst concurrent with a resolve: reset wins, and no entry is written.
- Counter saturation at all-ones holds the value; it does not wrap.

## Test plan
- Reset, then i_if_pc=0x40 → o_pred_taken=0, o_pred_pc=0x44, o_br_cnt=o_mp_cnt=0.
- BEQ at 0x40, imm=3, r1=r2=5, pred_taken=0 → o_redirect=1, o_redirect_pc=0x50, o_mp_cnt=1. Next cycle i_if_pc=0x40 → o_pred_taken=1, o_pred_pc=0x50.
- Same BEQ resolved with r1≠r2 twice → ctr 10→01→00, prediction not taken after the first; second resolve with pred_taken=0 gives o_redirect=0.
- BNE mispredict and i_es_change_pc=1, i_es_pc=0x1000 in the same cycle → o_redirect_pc=0x1000; no table or counter change.
- Index alias: taken branches at 0x40 and 0x80 (ENTRIES=16) → second evicts first; lookup at 0x40 misses. EXT_BRANCH=1 BLEZ r1=0xFFFFFFFF → taken.
- CNT_WIDTH=2: five resolved branches → o_br_cnt=3. i_stat_clr together with a resolve → 0. i_rst during a taken resolve → entry stays invalid.
